// File: rtl/onehot_pkg.sv
// Shared constants, FSM state encoding and helpers for the one-hot
// round-robin phase sequencer.
package onehot_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned NPH   = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Convert a one-hot (or zero) grant vector to its bit index.
  function automatic logic [IDX_W-1:0] oh2idx(input logic [NREQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin picker: searches upward from the
// requester after the previous winner and returns a one-hot winner.
module rr_arb4
  import onehot_pkg::*;
(
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [NREQ-1:0]  winner_c
);

  logic found;

  always_comb begin
    winner_c = '0;
    found    = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && req_i[IDX_W'(int'(last_i) + k)]) begin
        winner_c[IDX_W'(int'(last_i) + k)] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onehot_rr_sched.sv
// Round-robin granted phase sequencer: the winner owns a run of steps+1
// one-hot phases, followed by a single-cycle DONE (optionally aborted).
module onehot_rr_sched #(
  parameter int unsigned NREQ = onehot_pkg::NREQ,
  parameter int unsigned NPH  = onehot_pkg::NPH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req,
  input  logic [onehot_pkg::CNT_W-1:0] steps,
  input  logic                         abort,
  output logic [NREQ-1:0]              gnt,
  output logic                         busy,
  output logic [NPH-1:0]               one_hot,
  output logic [onehot_pkg::CNT_W-1:0] count,
  output logic                         done,
  output logic                         aborted
);

  import onehot_pkg::*;

  state_e            state_q,   state_d;
  logic [NREQ-1:0]   gnt_q,     gnt_d;
  logic [NPH-1:0]    one_hot_q, one_hot_d;
  logic [CNT_W-1:0]  count_q,   count_d;
  logic [CNT_W-1:0]  steps_q,   steps_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              aborted_q, aborted_d;
  logic [IDX_W-1:0]  last_q,    last_d;
  logic [3:0]        arb_win_c;

  rr_arb4 u_arb (
    .req_i    (4'(req)),
    .last_i   (last_q),
    .winner_c (arb_win_c)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    one_hot_d = one_hot_q;
    count_d   = count_q;
    steps_d   = steps_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    last_d    = last_q;

    unique case (state_q)
      ST_IDLE: begin
        gnt_d     = '0;
        one_hot_d = '0;
        count_d   = '0;
        busy_d    = 1'b0;
        if (|req) begin
          state_d   = ST_RUN;
          gnt_d     = NREQ'(arb_win_c);
          one_hot_d = NPH'(1);
          steps_d   = steps;
          busy_d    = 1'b1;
        end
      end
      ST_RUN: begin
        // Abort wins over normal completion; count is frozen into DONE.
        if (abort || (count_q == steps_q)) begin
          state_d   = ST_DONE;
          one_hot_d = '0;
          done_d    = 1'b1;
          aborted_d = abort;
        end else begin
          one_hot_d = {one_hot_q[NPH-2:0], one_hot_q[NPH-1]};
          count_d   = count_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        count_d = '0;
        busy_d  = 1'b0;
        last_d  = oh2idx(4'(gnt_q));
      end
      default: begin
        state_d   = ST_IDLE;
        gnt_d     = '0;
        one_hot_d = '0;
        count_d   = '0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      one_hot_q <= '0;
      count_q   <= '0;
      steps_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      last_q    <= IDX_W'(3);
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      one_hot_q <= one_hot_d;
      count_q   <= count_d;
      steps_q   <= steps_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      last_q    <= last_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign one_hot = one_hot_q;
  assign count   = count_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_onehot_rr_sched.sv
// Bench for onehot_rr_sched: directed scenarios plus random traffic, all
// outputs compared each cycle against a run-level behavioural model.
module tb_onehot_rr_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] steps;
  logic       abort;
  logic [3:0] gnt;
  logic       busy;
  logic [7:0] one_hot;
  logic [3:0] count;
  logic       done;
  logic       aborted;

  int checks   = 0;
  int failures = 0;

  // Model: mode 0 = waiting, 1 = phases running, 2 = completion cycle.
  int m_mode, m_win, m_k, m_steps, m_last;
  bit m_ab;

  onehot_rr_sched #(.NREQ(4), .NPH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .steps   (steps),
    .abort   (abort),
    .gnt     (gnt),
    .busy    (busy),
    .one_hot (one_hot),
    .count   (count),
    .done    (done),
    .aborted (aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_win = 0; m_k = 0; m_steps = 0; m_last = 3; m_ab = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] s, input logic a);
    case (m_mode)
      0: if (r != 4'd0) begin
        for (int i = 4; i >= 1; i--)
          if (r[(m_last + i) % 4]) m_win = (m_last + i) % 4;
        m_mode = 1; m_k = 0; m_steps = int'(s); m_ab = 1'b0;
      end
      1: begin
        if (a) begin m_mode = 2; m_ab = 1'b1; end
        else if (m_k == m_steps) begin m_mode = 2; m_ab = 1'b0; end
        else m_k++;
      end
      default: begin m_last = m_win; m_mode = 0; m_ab = 1'b0; m_k = 0; end
    endcase
  endtask

  task automatic check_all(input string tag);
    logic [3:0] eg;
    logic [7:0] eo;
    eg = (m_mode != 0) ? 4'(1 << m_win) : 4'd0;
    eo = (m_mode == 1) ? 8'(1 << (m_k % 8)) : 8'd0;
    chk({tag, ".gnt"},     32'(gnt),     32'(eg));
    chk({tag, ".busy"},    32'(busy),    32'(m_mode != 0));
    chk({tag, ".one_hot"}, 32'(one_hot), 32'(eo));
    chk({tag, ".count"},   32'(count),   (m_mode == 0) ? 32'd0 : 32'(m_k));
    chk({tag, ".done"},    32'(done),    32'(m_mode == 2));
    chk({tag, ".aborted"}, 32'(aborted), 32'((m_mode == 2) && m_ab));
  endtask

  task automatic cycle(input logic [3:0] r, input logic [3:0] s, input logic a, input string tag);
    req = r; steps = s; abort = a;
    model_step(r, s, a);
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic sync_reset();
    reset = 1'b1; req = '0; abort = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check_all("rst");
  endtask

  logic [3:0] order_q[$];
  logic [3:0] prev_gnt;
  logic [3:0] exp_order[5];

  initial begin
    reset = 1'b1; req = '0; steps = '0; abort = 1'b0;
    model_reset();
    #2;
    check_all("por");
    @(posedge clk); #1;
    reset = 1'b0;
    check_all("por_rel");

    // Single requester, 4 phases; abort while idle must be ignored.
    cycle(4'b0000, 4'd3, 1'b1, "idle_abort");
    cycle(4'b0001, 4'd3, 1'b0, "r030_grant");
    for (int i = 0; i < 6; i++) cycle(4'b0000, 4'd7, 1'b0, "r030");

    // Long run wraps the phase ring.
    cycle(4'b0100, 4'd9, 1'b0, "r031_grant");
    for (int i = 0; i < 9; i++) cycle(4'b0100, 4'd2, 1'b0, "r031");
    chk("r031_count9", 32'(count), 32'd9);
    chk("r031_onehot", 32'(one_hot), 32'h02);
    cycle(4'b0000, 4'd2, 1'b0, "r031_done");
    chk("r031_donepulse", 32'(done), 32'd1);
    cycle(4'b0000, 4'd2, 1'b0, "r031_idle");

    // All requesting: round-robin order from reset.
    sync_reset();
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    prev_gnt = 4'd0;
    for (int i = 0; i < 13; i++) begin
      cycle(4'b1111, 4'd0, 1'b0, "r032");
      if (gnt != 4'd0 && prev_gnt == 4'd0) order_q.push_back(gnt);
      prev_gnt = gnt;
    end
    cycle(4'b0000, 4'd0, 1'b0, "r032_tail");
    cycle(4'b0000, 4'd0, 1'b0, "r032_tail");
    chk("r032_ngrants", 32'(order_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < order_q.size(); i++)
      chk("r032_order", 32'(order_q[i]), 32'(exp_order[i]));

    // Abort at count 2 of a 16-phase run.
    cycle(4'b0001, 4'd15, 1'b0, "r033_grant");
    cycle(4'b0000, 4'd0, 1'b0, "r033");
    cycle(4'b0000, 4'd0, 1'b0, "r033");
    cycle(4'b0000, 4'd0, 1'b1, "r033_abort");
    chk("r033_done", 32'(done), 32'd1);
    chk("r033_aborted", 32'(aborted), 32'd1);
    chk("r033_count", 32'(count), 32'd2);
    chk("r033_onehot", 32'(one_hot), 32'd0);
    cycle(4'b0000, 4'd0, 1'b1, "r033_done_abort");
    cycle(4'b0000, 4'd0, 1'b0, "r033_idle");

    // Abort in the same cycle as normal completion; then req dropped mid-run.
    cycle(4'b0010, 4'd2, 1'b0, "r035a_grant");
    cycle(4'b0000, 4'd0, 1'b0, "r035a");
    cycle(4'b0000, 4'd0, 1'b0, "r035a");
    cycle(4'b0000, 4'd0, 1'b1, "r035a_abort");
    chk("r035a_aborted", 32'(aborted), 32'd1);
    cycle(4'b0000, 4'd0, 1'b0, "r035a_idle");
    cycle(4'b1000, 4'd4, 1'b0, "r035b_grant");
    for (int i = 0; i < 5; i++) cycle(4'b0000, 4'd1, 1'b0, "r035b");
    chk("r035b_done", 32'(done), 32'd1);
    chk("r035b_aborted", 32'(aborted), 32'd0);
    cycle(4'b0000, 4'd0, 1'b0, "r035b_idle");

    // Asynchronous reset at count 5, then priority restarts at requester 0.
    cycle(4'b0001, 4'd9, 1'b0, "r034_grant");
    for (int i = 0; i < 5; i++) cycle(4'b0000, 4'd9, 1'b0, "r034");
    chk("r034_count5", 32'(count), 32'd5);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("r034_async");
    @(posedge clk); #1;
    reset = 1'b0;
    check_all("r034_held");
    cycle(4'b0110, 4'd1, 1'b0, "r034_regrant");
    chk("r034_gnt", 32'(gnt), 32'b0010);
    cycle(4'b0000, 4'd0, 1'b0, "r034_tail");
    cycle(4'b0000, 4'd0, 1'b0, "r034_tail");
    cycle(4'b0000, 4'd0, 1'b0, "r034_tail");

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] rr;
      rr = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      cycle(rr, 4'($urandom_range(0, 15)), ($urandom_range(0, 11) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
